fir_ts_sequencer: RTL

Sequencer for the 4-phase time-shared symmetric FIR. It generates the sample and symbol clock enables and the multiplier phase index that drive the coefficient/tap muxes and accumulator clear. It also tracks pipeline fill so downstream logic knows when the filter output `y` is meaningful. Coefficient-bank switches requested on `sw` are applied only at symbol boundaries. The block sits between the system rate logic and the FIR datapath and is the sole source of the FIR's `sam_clk_en`, `sym_clk_en` and phase.

---
 rtl/fir_ts_pkg.sv | 20 ++
 rtl/fir_ts_sequencer_rate_gen.sv | 46 ++++
 rtl/fir_ts_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/fir_ts_pkg.sv
// Shared definitions for the time-shared FIR sequencer and datapath.
package fir_ts_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int DEF_PHASES          = 4;
    localparam int DEF_SAMPLES_PER_SYM = 4;
    localparam int DEF_FILL_SAMPLES    = 67;
    localparam int PHASE_W             = $clog2(DEF_PHASES);

    // Counter width that stays at least one bit for degenerate counts.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_ts_sequencer_rate_gen.sv
// Phase counter, sample counter and sample/symbol strobe generation.
module ts_rate_gen
    import fir_ts_pkg::*;
#(
    parameter int PHASES          = DEF_PHASES,
    parameter int SAMPLES_PER_SYM = DEF_SAMPLES_PER_SYM
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear,
    output logic                      sam_clk_en,
    output logic                      sym_clk_en,
    output logic [$clog2(PHASES)-1:0] phase
);

    localparam int PW = $clog2(PHASES);
    localparam int SW = cnt_width(SAMPLES_PER_SYM);
    localparam logic [PW-1:0] PHASE_PRE = PW'(PHASES - 2);
    localparam logic [SW-1:0] SAM_LAST  = SW'(SAMPLES_PER_SYM - 1);

    logic [SW-1:0] sam_cnt;
    logic          pre_strobe;

    // Strobes are registered, so they are decided one phase ahead of PHASES-1.
    assign pre_strobe = enable && (phase == PHASE_PRE);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= '0;
            sam_cnt    <= '0;
            sam_clk_en <= 1'b0;
            sym_clk_en <= 1'b0;
        end else begin
            phase      <= enable ? phase + PW'(1) : '0;
            sam_clk_en <= pre_strobe;
            sym_clk_en <= pre_strobe && (sam_cnt == SAM_LAST);
            if (clear) begin
                sam_cnt <= '0;
            end else if (sam_clk_en) begin
                sam_cnt <= (sam_cnt == SAM_LAST) ? '0 : sam_cnt + SW'(1);
            end
        end
    end

endmodule

// File: rtl/fir_ts_sequencer.sv
// Sequencer for the 4-phase time-shared FIR: FSM, fill tracking and bank control.
// Optional BANK_REFILL_EN: a bank change in RUN re-enters FILL so y_valid never covers mixed banks.
module fir_ts_sequencer
    import fir_ts_pkg::*;
#(
    parameter int PHASES          = DEF_PHASES,
    parameter int SAMPLES_PER_SYM = DEF_SAMPLES_PER_SYM,
    parameter int FILL_SAMPLES    = DEF_FILL_SAMPLES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run,
    input  logic [1:0]                sw,
    output logic                      sam_clk_en,
    output logic                      sym_clk_en,
    output logic [$clog2(PHASES)-1:0] phase,
    output logic                      acc_clr,
    output logic [1:0]                coeff_bank,
    output logic                      y_valid,
    output logic [1:0]                state
);

    localparam int FW = cnt_width(FILL_SAMPLES);
    localparam logic [FW-1:0] FILL_LAST = FW'(FILL_SAMPLES - 1);

    state_t        state_q;
    logic [FW-1:0] fill_cnt;
    logic          bank_change;
    logic          go_idle;
    logic          refill;

    assign bank_change = sym_clk_en && (sw != coeff_bank);
    assign go_idle     = sam_clk_en && !run && (state_q != IDLE);

`ifdef BANK_REFILL_EN
    assign refill = bank_change && run && (state_q == RUN);
`else
    assign refill = 1'b0;
`endif

    ts_rate_gen #(
        .PHASES          (PHASES),
        .SAMPLES_PER_SYM (SAMPLES_PER_SYM)
    ) u_rate_gen (
        .clk        (clk),
        .reset      (reset),
        .enable     (state_q != IDLE),
        .clear      (go_idle || refill),
        .sam_clk_en (sam_clk_en),
        .sym_clk_en (sym_clk_en),
        .phase      (phase)
    );

    assign acc_clr = (phase == '0);
    assign state   = state_q;

    // A dropped run is only honoured at a sample strobe so the last sample completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fill_cnt   <= '0;
            coeff_bank <= 2'd0;
            y_valid    <= 1'b0;
        end else begin
            if (bank_change) begin
                coeff_bank <= sw;
            end
            case (state_q)
                IDLE: begin
                    fill_cnt <= '0;
                    y_valid  <= 1'b0;
                    if (run) begin
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (go_idle) begin
                        state_q  <= IDLE;
                        fill_cnt <= '0;
                        y_valid  <= 1'b0;
                    end else if (sam_clk_en) begin
                        if (fill_cnt == FILL_LAST) begin
                            state_q  <= RUN;
                            fill_cnt <= '0;
                            y_valid  <= 1'b1;
                        end else begin
                            fill_cnt <= fill_cnt + FW'(1);
                        end
                    end
                end
                RUN: begin
                    if (go_idle) begin
                        state_q  <= IDLE;
                        fill_cnt <= '0;
                        y_valid  <= 1'b0;
                    end else if (refill) begin
                        state_q  <= FILL;
                        fill_cnt <= '0;
                        y_valid  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    fill_cnt <= '0;
                    y_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule
